// File: rtl/barrel_spawn_scheduler.sv
// rtl/barrel_spawn_scheduler.sv - arbitrates auto/key spawn requests onto the lowest free barrel slot
module barrel_spawn_scheduler #(
  parameter int BARRELS    = 5,
  parameter int DELAY_TIME = 162_500_000,
  parameter int MIN_GAP    = 6_500_000,
  parameter int CNT_W      = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_game,
  input  logic                           animation,
  input  logic                           key,
  input  logic [BARRELS-1:0]             done,
  output logic [BARRELS-1:0]             barrel,
  output logic                           spawn,
  output logic [$clog2(BARRELS)-1:0]     spawn_slot,
  output logic                           spawn_src,
  output logic [$clog2(BARRELS+1)-1:0]   active_cnt,
  output logic [CNT_W-1:0]               drop_cnt
);

  localparam int SLOT_W  = $clog2(BARRELS);
  localparam int ACT_W   = $clog2(BARRELS + 1);
  localparam int TIMER_W = $clog2(DELAY_TIME);
  localparam int GAP_W   = $clog2(MIN_GAP + 1);

  typedef enum logic [1:0] {IDLE, ARMED, GAP} state_t;

  state_t               state_q;
  logic [TIMER_W-1:0]   timer_q;
  logic [GAP_W-1:0]     gap_q;
  logic                 auto_pend_q;
  logic                 key_pend_q;
  logic                 key_q;
  logic                 rr_q;
  logic [BARRELS-1:0]   barrel_q;
  logic                 spawn_q;
  logic [SLOT_W-1:0]    slot_q;
  logic                 src_q;
  logic [ACT_W-1:0]     active_q;
  logic [CNT_W-1:0]     drop_q;

  logic                 enable;
  logic                 run;
  logic                 key_edge;
  logic                 timer_tc;
  logic                 free_found;
  logic [SLOT_W-1:0]    free_slot;
  logic                 grant;
  logic                 grant_key;
  logic                 grant_auto;
  logic [BARRELS-1:0]   barrel_d;
  logic [ACT_W-1:0]     active_d;

  always_comb begin
    enable   = start_game & ~animation;
    run      = enable & (state_q != IDLE);
    key_edge = run & key & ~key_q;
    timer_tc = run & (timer_q == TIMER_W'(DELAY_TIME - 1));

    // Descending scan so the last hit is the lowest free index.
    free_found = 1'b0;
    free_slot  = '0;
    for (int i = BARRELS - 1; i >= 0; i--) begin
      if (!barrel_q[i]) begin
        free_found = 1'b1;
        free_slot  = SLOT_W'(i);
      end
    end

    grant      = run & (state_q == ARMED) & (auto_pend_q | key_pend_q) & free_found;
    grant_key  = grant & key_pend_q & (~auto_pend_q | rr_q);
    grant_auto = grant & ~grant_key;

    barrel_d = barrel_q & ~done;
    if (grant) begin
      barrel_d[free_slot] = 1'b1;
    end
    if (!enable) begin
      barrel_d = '0;
    end

    active_d = '0;
    for (int i = 0; i < BARRELS; i++) begin
      active_d = active_d + ACT_W'(barrel_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      gap_q       <= '0;
      auto_pend_q <= 1'b0;
      key_pend_q  <= 1'b0;
      key_q       <= 1'b0;
      rr_q        <= 1'b0;
      barrel_q    <= '0;
      spawn_q     <= 1'b0;
      slot_q      <= '0;
      src_q       <= 1'b0;
      active_q    <= '0;
      drop_q      <= '0;
    end else begin
      key_q    <= key;
      barrel_q <= barrel_d;
      active_q <= active_d;
      spawn_q  <= grant;

      if (grant) begin
        slot_q <= free_slot;
        src_q  <= grant_key;
      end
      if (grant && auto_pend_q && key_pend_q) begin
        rr_q <= ~rr_q;
      end
      if (key_edge && key_pend_q && !(&drop_q)) begin
        drop_q <= drop_q + 1'b1;
      end

      if (!run) begin
        timer_q     <= '0;
        auto_pend_q <= 1'b0;
        key_pend_q  <= 1'b0;
      end else begin
        timer_q     <= timer_tc ? '0 : timer_q + 1'b1;
        // A terminal count in the same cycle as an auto grant re-arms the request.
        auto_pend_q <= timer_tc | (auto_pend_q & ~grant_auto);
        key_pend_q  <= (key_edge & ~key_pend_q) | (key_pend_q & ~grant_key);
      end

      if (!enable) begin
        state_q <= IDLE;
        gap_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= ARMED;
            gap_q   <= '0;
          end
          ARMED: begin
            if (grant) begin
              state_q <= GAP;
              gap_q   <= GAP_W'(MIN_GAP - 1);
            end
          end
          GAP: begin
            if (gap_q == '0) begin
              state_q <= ARMED;
            end else begin
              gap_q <= gap_q - 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            gap_q   <= '0;
          end
        endcase
      end
    end
  end

  assign barrel     = barrel_q;
  assign spawn      = spawn_q;
  assign spawn_slot = slot_q;
  assign spawn_src  = src_q;
  assign active_cnt = active_q;
  assign drop_cnt   = drop_q;

endmodule
